lsu_ram_bridge: RTL and testbench

Load/store unit between the core datapath and the word-addressed data RAM. It accepts one byte-addressed RV32I load or store request at a time and translates it into word accesses. It sign- or zero-extends load data and performs read-modify-write for byte and halfword stores. Misaligned, out-of-range and illegal-funct3 requests are rejected without touching memory.

---
 rtl/lsu_ram_bridge_pkg.sv | 38 +++
 rtl/lsu_ram_bridge_if.sv | 34 +++
 rtl/lsu_ram_bridge_extend.sv | 51 +++++
 rtl/lsu_ram_bridge.sv | 135 +++++++++++++
 tb/tb_lsu_ram_bridge.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_ram_bridge_pkg.sv
// Shared definitions for the load/store unit to data-RAM bridge.
// Contents:
//   F3_*          RV32I funct3 encodings for loads and stores
//   lsu_state_t   bridge FSM state
//   funct3_legal  1 when funct3 is a legal load (store=0) or store (store=1)
//   misaligned    1 when the byte offset is not aligned to the access size
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStoreRd,
    StStoreWr
  } lsu_state_t;

  function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
    if (store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] gives the access size for every legal encoding (00 byte, 01 half, 10 word).
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ram_bridge_if.sv
// Request/response bus between the core datapath and the load/store bridge.
// Signals:
//   req_valid/req_ready   request handshake (accepted when both high at posedge)
//   req_store             1 = store, 0 = load
//   req_funct3            RV32I funct3
//   req_addr              byte address
//   req_wdata             right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_err              request rejected
//   resp_rdata            extended load data (0 for stores and errors)
// Modports: master = requester (core), slave = bridge.
interface lsu_ram_bridge_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );

endinterface

// File: rtl/lsu_ram_bridge_extend.sv
// Combinational byte-lane logic shared by the load and store paths.
// Ports:
//   word       RAM word (load source, or old word for a store merge)
//   wdata      right-aligned store data
//   byte_off   byte address bits [1:0]
//   funct3     RV32I funct3
//   load_data  extracted and sign/zero-extended load result
//   merged     word with the store byte/half inserted (SW: wdata)
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{byte_off, 3'b000} +: 8];
    half_v = byte_off[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h0, byte_v};
      F3_HU:   load_data = {16'h0, half_v};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3[1:0])
      2'b00: merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      2'b10:   merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_ram_bridge.sv
// Load/store unit bridge: turns one byte-addressed RV32I load/store request at a time into
// word accesses on a word-addressed RAM with combinational read data. Sub-word stores are
// done as read-modify-write. Misaligned, out-of-range and illegal-funct3 requests are
// rejected without any RAM access.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   bus          request/response bus (slave side)
//   address      RAM word index (req_addr[31:2]), held while idle
//   write_data   RAM write data
//   MemWrite     RAM write strobe (forced low while reset is asserted)
//   MemRead      RAM read qualifier
//   read_data    RAM read data for address
module lsu_ram_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  lsu_ram_bridge_if.slave         bus,
  output logic [31:0]             address,
  output logic [31:0]             write_data,
  output logic                    MemWrite,
  output logic                    MemRead,
  input  logic [31:0]             read_data
);

  lsu_state_t  state_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [31:0] address_q;
  logic [31:0] write_data_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    req_err = !funct3_legal(bus.req_store, bus.req_funct3) ||
              misaligned(bus.req_funct3, bus.req_addr[1:0]) ||
              ({2'b00, bus.req_addr[31:2]} >= DEPTH);
  end

  // Both paths read the RAM word for the latched address; only one is used per state.
  lsu_extend u_extend (
    .word      (read_data),
    .wdata     (wdata_q),
    .byte_off  (off_q),
    .funct3    (funct3_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      off_q        <= '0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            off_q    <= bus.req_addr[1:0];
            funct3_q <= bus.req_funct3;
            wdata_q  <= bus.req_wdata;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              address_q <= {2'b00, bus.req_addr[31:2]};
              if (!bus.req_store) begin
                state_q    <= StLoad;
                mem_read_q <= 1'b1;
              end else if (bus.req_funct3 == F3_W) begin
                // Full word needs no read-back.
                state_q      <= StStoreWr;
                mem_write_q  <= 1'b1;
                write_data_q <= bus.req_wdata;
              end else begin
                state_q    <= StStoreRd;
                mem_read_q <= 1'b1;
              end
            end
          end
        end
        StLoad: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
          state_q      <= StIdle;
        end
        StStoreRd: begin
          // write_data doubles as the merge register.
          write_data_q <= merged;
          mem_write_q  <= 1'b1;
          state_q      <= StStoreWr;
        end
        StStoreWr: begin
          resp_valid_q <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign address        = address_q;
  assign write_data     = write_data_q;
  assign MemRead        = mem_read_q;
  // Reset in the write cycle must leave the RAM word untouched.
  assign MemWrite       = mem_write_q & ~reset;

endmodule

// File: tb/tb_lsu_ram_bridge.sv
// Self-checking bench for lsu_ram_bridge: directed plan cases followed by random requests,
// checked against a reference memory and access rules computed in plain arithmetic.
module tb_lsu_ram_bridge;

  localparam int unsigned DEPTH = 1024;
  localparam int          AW    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] read_data;
  logic        preload;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_addr = '0;

  lsu_ram_bridge_if bus ();

  lsu_ram_bridge #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .address    (address),
    .write_data (write_data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  // Environment RAM: combinational read, write on posedge.
  assign read_data = ram[address[AW-1:0]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
    end else if (MemWrite) begin
      ram[address[AW-1:0]] <= write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic logic m_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    logic mis;
    legal = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                 f3 == 3'd4 || f3 == 3'd5);
    mis = 1'b0;
    if (f3[1:0] == 2'd1) mis = (a % 2) != 0;
    if (f3[1:0] == 2'd2) mis = (a % 4) != 0;
    return !legal || mis || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    if (f3 == 3'd2) return w;
    if (f3[1:0] == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 == 3'd0 && v > 127) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v > 32767) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] mask;
    int sh;
    if (f3 == 3'd2) return wd;
    if (f3 == 3'd0) begin
      sh   = 8 * int'(a % 4);
      mask = 32'hFF << sh;
    end else begin
      sh   = 16 * int'((a % 4) / 2);
      mask = 32'hFFFF << sh;
    end
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Issue one request (called just after a negedge while idle); follows it cycle by cycle.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic rdy0, output int lat,
                        output logic err, output logic [31:0] rd, output int n_rd,
                        output int n_wr, output int rd_cyc, output int wr_cyc);
    rdy0 = bus.req_ready;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    lat = -1; err = 1'bx; rd = 'x;
    n_rd = 0; n_wr = 0; rd_cyc = -1; wr_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_valid = 1'b0;
      if (MemRead)  begin n_rd++; rd_cyc = c; end
      if (MemWrite) begin n_wr++; wr_cyc = c; end
      if (bus.resp_valid) begin
        lat = c;
        err = bus.resp_err;
        rd  = bus.resp_rdata;
        break;
      end
    end
  endtask

  task automatic run_and_check(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input string tag,
                               output logic [31:0] rd);
    logic rdy0, err, e_err;
    int lat, n_rd, n_wr, rd_cyc, wr_cyc;
    int e_lat, e_rd, e_wr;
    logic [31:0] e_data;
    int idx;
    do_req(st, f3, a, wd, rdy0, lat, err, rd, n_rd, n_wr, rd_cyc, wr_cyc);
    e_err  = m_err(st, f3, a);
    idx    = int'((a / 4) % DEPTH);
    e_data = '0;
    if (e_err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (!st) begin
      e_lat = 2; e_rd = 1; e_wr = 0;
      e_data = m_load(ref_mem[idx], f3, a);
      exp_addr = a / 4;
    end else begin
      e_lat = (f3 == 3'd2) ? 2 : 3;
      e_rd  = (f3 == 3'd2) ? 0 : 1;
      e_wr  = 1;
      ref_mem[idx] = m_store(ref_mem[idx], wd, f3, a);
      exp_addr = a / 4;
    end
    chk({tag, " req_ready"}, 32'(rdy0), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " resp_err"}, 32'(err), 32'(e_err));
    chk({tag, " resp_rdata"}, rd, e_data);
    chk({tag, " MemRead cycles"}, 32'(n_rd), 32'(e_rd));
    chk({tag, " MemWrite cycles"}, 32'(n_wr), 32'(e_wr));
    chk({tag, " address"}, address, exp_addr);
    if (e_rd == 1) chk({tag, " MemRead cycle"}, 32'(rd_cyc), 32'd1);
    if (e_wr == 1) begin
      chk({tag, " MemWrite cycle"}, 32'(wr_cyc), 32'(e_lat - 1));
      chk({tag, " ram word"}, ram[idx], ref_mem[idx]);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
    chk({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, " MemWrite"}, 32'(MemWrite), 32'd0);
    chk({tag, " MemRead"}, 32'(MemRead), 32'd0);
    chk({tag, " address"}, address, 32'd0);
    chk({tag, " write_data"}, write_data, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        st;
    logic [2:0]  f3;
    int          sel, bad, seen_rv, seen_wr;

    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom();
    ref_mem[3] = 32'h8765_43F1;
    reset   = 1'b1;
    preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    reset   = 1'b0;
    chk_reset_vals("reset");

    // Plan loads from word 3.
    run_and_check(1'b0, 3'b000, 32'h0C, 32'h0, "LB", rd);
    chk("LB const", rd, 32'hFFFF_FFF1);
    run_and_check(1'b0, 3'b100, 32'h0C, 32'h0, "LBU", rd);
    chk("LBU const", rd, 32'h0000_00F1);
    run_and_check(1'b0, 3'b001, 32'h0E, 32'h0, "LH", rd);
    chk("LH const", rd, 32'hFFFF_8765);
    run_and_check(1'b0, 3'b101, 32'h0E, 32'h0, "LHU", rd);
    chk("LHU const", rd, 32'h0000_8765);

    run_and_check(1'b1, 3'b000, 32'h0D, 32'h0000_00AA, "SB", rd);
    chk("SB word3 const", ram[3], 32'h8765_AAF1);

    // SW then LW accepted in the SW response cycle.
    run_and_check(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "SW", rd);
    run_and_check(1'b0, 3'b010, 32'h10, 32'h0, "LW b2b", rd);
    chk("LW b2b const", rd, 32'hDEAD_BEEF);

    run_and_check(1'b0, 3'b010, 32'h0E, 32'h0, "err LW mis", rd);
    run_and_check(1'b1, 3'b001, 32'h1001, 32'h0, "err SH mis", rd);
    run_and_check(1'b0, 3'b010, 32'h1000, 32'h0, "err LW range", rd);
    run_and_check(1'b0, 3'b011, 32'h0C, 32'h0, "err f3 011", rd);
    run_and_check(1'b0, 3'b010, 32'h0FFC, 32'h0, "LW last word", rd);

    // Restore word 3, then SH with reset asserted during the write cycle.
    run_and_check(1'b1, 3'b010, 32'h0C, 32'h8765_43F1, "SW restore", rd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'h0C;
    bus.req_wdata  = 32'h0000_1234;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("SH rst MemRead c1", 32'(MemRead), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    seen_rv = 0; seen_wr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.resp_valid) seen_rv++;
      if (MemWrite) seen_wr++;
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.resp_valid) seen_rv++;
      if (MemWrite) seen_wr++;
      if (c < 2) @(negedge clk);
    end
    chk("SH rst MemWrite", 32'(seen_wr), 32'd0);
    chk("SH rst resp_valid", 32'(seen_rv), 32'd0);
    chk("SH rst word3", ram[3], 32'h8765_43F1);
    chk_reset_vals("post-reset");
    exp_addr = '0;

    // Random requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = $urandom_range(32'h0FF0, 32'h100F);
      else if (sel == 1) a = $urandom();
      else               a = $urandom_range(0, 255);
      wd = $urandom();
      run_and_check(st, f3, a, wd, "rand", rd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("final ram image mismatched words", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
